// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, control bit map and register constants for the MIPS core
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 8;

   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMREAD  = 1;
   localparam int CTRL_MEMWRITE = 2;
   localparam int CTRL_MEMTOREG = 3;
   localparam int CTRL_REGDST   = 4;
   localparam int CTRL_ALUSRC   = 5;
   localparam int CTRL_ALUOP    = 6;
   localparam int CTRL_ALUOP_W  = 2;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // True when a writeback to wb_rd must be seen by a read of rd this cycle.
   function automatic logic wb_hits(input logic wb_regwrite, input logic [4:0] wb_rd,
                                    input logic [4:0] rd);
      return wb_regwrite && (rd != REG_ZERO) && (wb_rd == rd);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard comparator
module hazard_detect
   import mips_pkg::*;
(
   input  logic       i_id_valid,
   input  logic [4:0] i_id_rs,
   input  logic [4:0] i_id_rt,
   input  logic       i_ex_valid,
   input  logic       i_ex_memread,
   input  logic [4:0] i_ex_rt,
   output logic       o_stall
);

   logic w_rt_hit;

   assign w_rt_hit = (i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt);
   assign o_stall  = i_id_valid && i_ex_valid && i_ex_memread &&
                     (i_ex_rt != REG_ZERO) && w_rt_hit;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB write-through bypass and load-use bubble
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int CTRL_W = mips_pkg::CTRL_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [DATA_W-1:0] rf_rdata1,
   input  logic [DATA_W-1:0] rf_rdata2,
   input  logic              wb_regwrite,
   input  logic [4:0]        wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              stall,
   output logic              ex_valid,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [15:0]       stall_cnt
);

   logic              r_valid;
   logic [4:0]        r_rs;
   logic [4:0]        r_rt;
   logic [4:0]        r_rd;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_imm;
   logic [CTRL_W-1:0] r_ctrl;
   logic [15:0]       r_stall_cnt;

   logic              w_stall;
   logic              w_bubble;
   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;

   hazard_detect u_hazard (
      .i_id_valid   (id_valid),
      .i_id_rs      (id_rs),
      .i_id_rt      (id_rt),
      .i_ex_valid   (r_valid),
      .i_ex_memread (r_ctrl[CTRL_MEMREAD]),
      .i_ex_rt      (r_rt),
      .o_stall      (w_stall)
   );

   assign w_bubble = flush || w_stall;

   // Register file writes on the edge we capture on, so its read ports are one write stale.
   always_comb begin
      w_op_a = rf_rdata1;
      if (id_rs == REG_ZERO)
         w_op_a = '0;
      else if (wb_hits(wb_regwrite, wb_rd, id_rs))
         w_op_a = wb_data;
   end

   always_comb begin
      w_op_b = rf_rdata2;
      if (id_rt == REG_ZERO)
         w_op_b = '0;
      else if (wb_hits(wb_regwrite, wb_rd, id_rt))
         w_op_b = wb_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_rs        <= '0;
         r_rt        <= '0;
         r_rd        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_imm       <= '0;
         r_ctrl      <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_rs  <= id_rs;
         r_rt  <= id_rt;
         r_rd  <= id_rd;
         r_a   <= w_op_a;
         r_b   <= w_op_b;
         r_imm <= id_imm;
         if (w_bubble) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
         end else begin
            r_valid <= id_valid;
            r_ctrl  <= id_valid ? id_ctrl : '0;
         end
         if (w_stall && !flush && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall     = w_stall;
   assign ex_valid  = r_valid;
   assign ex_rs     = r_rs;
   assign ex_rt     = r_rt;
   assign ex_rd     = r_rd;
   assign ex_a      = r_a;
   assign ex_b      = r_b;
   assign ex_imm    = r_imm;
   assign ex_ctrl   = r_ctrl;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed scoreboard bench for id_ex_stage
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_imm;
   logic [7:0]  id_ctrl;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic        stall;
   logic        ex_valid;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [31:0] ex_a, ex_b, ex_imm;
   logic [7:0]  ex_ctrl;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_imm(id_imm), .id_ctrl(id_ctrl),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .stall(stall), .ex_valid(ex_valid),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
      .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic        valid;
      logic [4:0]  rs, rt, rd;
      logic [31:0] a, b, imm;
      logic [7:0]  ctrl;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   exp_t m;
   int   errors = 0;
   int   checks = 0;

   localparam logic [7:0] LW  = 8'h2B;
   localparam logic [7:0] ADD = 8'h91;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic rst, input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm,
                        input logic [7:0] ctrl, input logic [31:0] d1, input logic [31:0] d2,
                        input logic ww, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic fl);
      exp_t e;
      exp_t p;
      logic s;
      rst_n = rst; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_imm = imm;
      id_ctrl = ctrl; rf_rdata1 = d1; rf_rdata2 = d2;
      wb_regwrite = ww; wb_rd = wrd; wb_data = wd; flush = fl;
      #1;
      s = v && m.valid && m.ctrl[1] && (m.rt != 5'd0) && ((m.rt == rs) || (m.rt == rt));
      chk("stall", {63'd0, stall}, {63'd0, s});
      e.valid = (fl || s) ? 1'b0 : v;
      e.ctrl  = (fl || s || !v) ? 8'h00 : ctrl;
      e.rs = rs; e.rt = rt; e.rd = rd; e.imm = imm;
      e.a = (rs == 5'd0) ? 32'd0 : (ww && wrd == rs) ? wd : d1;
      e.b = (rt == 5'd0) ? 32'd0 : (ww && wrd == rt) ? wd : d2;
      e.cnt = (s && !fl && m.cnt != 16'hFFFF) ? m.cnt + 16'd1 : m.cnt;
      if (!rst) e = '{default: '0};
      q.push_back(e);
      m = e;
      @(negedge clk);
      p = q.pop_front();
      chk("ex_valid", {63'd0, ex_valid}, {63'd0, p.valid});
      chk("ex_rs", {59'd0, ex_rs}, {59'd0, p.rs});
      chk("ex_rt", {59'd0, ex_rt}, {59'd0, p.rt});
      chk("ex_rd", {59'd0, ex_rd}, {59'd0, p.rd});
      chk("ex_a", {32'd0, ex_a}, {32'd0, p.a});
      chk("ex_b", {32'd0, ex_b}, {32'd0, p.b});
      chk("ex_imm", {32'd0, ex_imm}, {32'd0, p.imm});
      chk("ex_ctrl", {56'd0, ex_ctrl}, {56'd0, p.ctrl});
      chk("stall_cnt", {48'd0, stall_cnt}, {48'd0, p.cnt});
   endtask

   initial begin
      m = '{default: '0};
      // reset: two cycles of random inputs
      rst_n = 0; id_valid = 1; id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
      id_imm = $urandom; id_ctrl = 8'hFF; rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      wb_regwrite = 1; wb_rd = 5'($urandom); wb_data = $urandom; flush = 0;
      @(negedge clk);
      cycle(0, 1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, 8'hFF,
            $urandom, $urandom, 1, 5'($urandom), $urandom, 0);
      chk("rst_valid", {63'd0, ex_valid}, 64'd0);
      chk("rst_cnt", {48'd0, stall_cnt}, 64'd0);

      // pass-through
      cycle(1, 1, 3, 4, 2, 32'h7, 8'h31, 32'h11, 32'h22, 0, 0, 0, 0);
      chk("pt_a", {32'd0, ex_a}, 64'h11);
      chk("pt_b", {32'd0, ex_b}, 64'h22);
      chk("pt_ctrl", {56'd0, ex_ctrl}, 64'h31);
      chk("pt_valid", {63'd0, ex_valid}, 64'd1);

      // WB bypass on B, on A, and $zero
      cycle(1, 1, 3, 4, 2, 0, ADD, 32'h11, 32'h22, 1, 4, 32'hDEAD, 0);
      chk("byp_b", {32'd0, ex_b}, 64'hDEAD);
      cycle(1, 1, 7, 4, 2, 0, ADD, 32'h11, 32'h22, 1, 7, 32'hBEEF, 0);
      chk("byp_a", {32'd0, ex_a}, 64'hBEEF);
      cycle(1, 1, 3, 0, 2, 0, ADD, 32'h11, 32'h22, 1, 0, 32'hDEAD, 0);
      chk("zero_b", {32'd0, ex_b}, 64'd0);
      cycle(1, 1, 0, 0, 2, 0, ADD, 32'h55, 32'h66, 0, 0, 0, 0);

      // invalid ID slot masks control
      cycle(1, 0, 3, 4, 2, 0, 8'hFF, 32'h1, 32'h2, 0, 0, 0, 0);
      chk("inv_ctrl", {56'd0, ex_ctrl}, 64'd0);

      // load-use on rs
      cycle(1, 1, 1, 5, 0, 32'h4, LW, 32'h100, 32'h0, 0, 0, 0, 0);
      cycle(1, 1, 5, 6, 8, 0, ADD, 32'h9, 32'h3, 0, 0, 0, 0);
      chk("lu_ctrl", {56'd0, ex_ctrl}, 64'd0);
      chk("lu_cnt", {48'd0, stall_cnt}, 64'd1);
      cycle(1, 1, 5, 6, 8, 0, ADD, 32'h9, 32'h3, 1, 5, 32'h77, 0);
      chk("lu_add", {56'd0, ex_ctrl}, {56'd0, ADD});
      chk("lu_cnt2", {48'd0, stall_cnt}, 64'd1);

      // load to $0: no stall
      cycle(1, 1, 1, 0, 0, 32'h8, LW, 32'h100, 32'h0, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 8, 0, ADD, 32'h9, 32'h3, 0, 0, 0, 0);

      // load, dependent load, dependent use: two stalls
      cycle(1, 1, 1, 5, 0, 32'h4, LW, 32'h100, 32'h0, 0, 0, 0, 0);
      cycle(1, 1, 5, 7, 0, 32'h8, LW, 32'h200, 32'h0, 0, 0, 0, 0);
      cycle(1, 1, 5, 7, 0, 32'h8, LW, 32'h200, 32'h0, 1, 5, 32'h200, 0);
      cycle(1, 1, 7, 1, 9, 0, ADD, 32'h5, 32'h100, 0, 0, 0, 0);
      cycle(1, 1, 7, 1, 9, 0, ADD, 32'h5, 32'h100, 1, 7, 32'h42, 0);
      chk("b2b_cnt", {48'd0, stall_cnt}, 64'd3);

      // load-use on rt
      cycle(1, 1, 1, 9, 0, 32'h4, LW, 32'h100, 32'h0, 0, 0, 0, 0);
      cycle(1, 1, 2, 9, 0, 32'h0, 8'h24, 32'h100, 32'h0, 0, 0, 0, 0);
      cycle(1, 1, 2, 9, 0, 32'h0, 8'h24, 32'h100, 32'h0, 0, 0, 0, 0);

      // flush during stall: bubble, counter unchanged
      cycle(1, 1, 1, 5, 0, 32'h4, LW, 32'h100, 32'h0, 0, 0, 0, 0);
      cycle(1, 1, 5, 6, 8, 0, ADD, 32'h9, 32'h3, 0, 0, 0, 1);
      chk("fl_cnt", {48'd0, stall_cnt}, 64'd4);
      chk("fl_valid", {63'd0, ex_valid}, 64'd0);
      cycle(1, 1, 5, 6, 8, 0, ADD, 32'h9, 32'h3, 0, 0, 0, 0);
      cycle(1, 1, 3, 4, 8, 0, ADD, 32'h9, 32'h3, 0, 0, 0, 1);

      // reset asserted mid-stall
      cycle(1, 1, 1, 5, 0, 32'h4, LW, 32'h100, 32'h0, 0, 0, 0, 0);
      cycle(0, 1, 5, 6, 8, 0, ADD, 32'h9, 32'h3, 0, 0, 0, 0);
      cycle(1, 1, 5, 6, 8, 0, ADD, 32'h9, 32'h3, 0, 0, 0, 0);

      // saturation: preload counter then three more stalls
      force dut.r_stall_cnt = 16'hFFFE;
      m.cnt = 16'hFFFE;
      cycle(1, 1, 3, 4, 8, 0, ADD, 32'h9, 32'h3, 0, 0, 0, 0);
      release dut.r_stall_cnt;
      for (int i = 0; i < 3; i++) begin
         cycle(1, 1, 1, 5, 0, 32'h4, LW, 32'h100, 32'h0, 0, 0, 0, 0);
         cycle(1, 1, 5, 6, 8, 0, ADD, 32'h9, 32'h3, 0, 0, 0, 0);
         chk("sat_cnt", {48'd0, stall_cnt}, 64'hFFFF);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
